// File: rtl/seg7_pkg.sv
// seg7_pkg: glyph table, FSM encoding and frame width shared by the scan reader.
package seg7_pkg;
    localparam int DIGITS = 4;
    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;
    // Alternate renderings some drivers use: 7 with segment f, 9 without segment d.
    localparam logic [6:0] SEG_7_F  = 7'h72;
    localparam logic [6:0] SEG_9_ND = 7'h73;
    typedef enum logic [1:0] {SCAN, CONV, DONE} state_e;
endpackage

// File: rtl/seg7_glyph_dec.sv
// seg7_glyph_dec: active-high {a..g} glyph to BCD, flagging anything that is not 0-9.
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       bad_o,
    output logic [3:0] bcd_o
);
    always_comb begin
        bad_o = 1'b0;
        bcd_o = 4'd0;
        case (seg_i)
            SEG_0:           bcd_o = 4'd0;
            SEG_1:           bcd_o = 4'd1;
            SEG_2:           bcd_o = 4'd2;
            SEG_3:           bcd_o = 4'd3;
            SEG_4:           bcd_o = 4'd4;
            SEG_5:           bcd_o = 4'd5;
            SEG_6:           bcd_o = 4'd6;
            SEG_7, SEG_7_F:  bcd_o = 4'd7;
            SEG_8:           bcd_o = 4'd8;
            SEG_9, SEG_9_ND: bcd_o = 4'd9;
            default:         bad_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: samples a multiplexed 4-digit 7-segment bus, assembles a frame
// of BCD digits and converts it to binary (0..9999).
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit EN_ACT_LOW  = 1'b0,
    parameter int SETTLE_CYC  = 8,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  abcdefg,
    input  logic        en0,
    input  logic        en1,
    input  logic        en2,
    input  logic        en3,
    output logic [15:0] bin,
    output logic        bin_valid,
    output logic        seg_err,
    output logic        busy
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [11:0] meta_q, sync_q;
    logic [3:0] en_n;
    logic [6:0] seg_n;
    logic unused_dp;
    logic [10:0] word_q;
    logic [SW-1:0] stab_q, stab_d;
    logic stable, cap, dec_bad, full, start, timeout;
    logic [3:0] dec_bcd;
    logic [1:0] idx, step_q, step_d;
    state_e state_q, state_d;
    logic [DIGITS-1:0][3:0] slot_q, slot_d, conv_q, conv_d;
    logic [DIGITS-1:0] bad_q, bad_d, mask_q, mask_d;
    logic [TW-1:0] to_q, to_d;
    logic [13:0] acc_q, acc_d, acc_mul;
    logic [15:0] bin_q, bin_d;

    // en_n[k] is the enable of slot k; slot 0 is the thousands digit.
    assign en_n      = EN_ACT_LOW ? ~sync_q[11:8] : sync_q[11:8];
    assign seg_n     = SEG_ACT_LOW ? ~sync_q[6:0] : sync_q[6:0];
    assign unused_dp = sync_q[7];

    // The counter passes SETTLE_CYC-1 exactly once per dwell, so each dwell samples once.
    assign stable = {en_n, seg_n} == word_q;
    assign stab_d = !stable ? '0 : (stab_q == SW'(SETTLE_CYC)) ? stab_q : stab_q + 1'b1;
    assign cap    = stable && stab_q == SW'(SETTLE_CYC - 1) && $onehot(en_n);
    assign idx    = en_n[3] ? 2'd3 : en_n[2] ? 2'd2 : en_n[1] ? 2'd1 : 2'd0;

    seg7_glyph_dec u_dec (
        .seg_i (seg_n),
        .bad_o (dec_bad),
        .bcd_o (dec_bcd)
    );

    assign full    = &mask_q;
    assign seg_err = full && |bad_q;
    assign start   = full && !(|bad_q) && state_q == SCAN;
    assign timeout = to_q == TW'(TIMEOUT_CYC);
    assign acc_mul = (acc_q << 3) + (acc_q << 1);

    always_comb begin
        slot_d  = slot_q;
        bad_d   = bad_q;
        mask_d  = (seg_err || start || timeout) ? '0 : mask_q;
        to_d    = (mask_q == '0 || cap) ? '0 : timeout ? to_q : to_q + 1'b1;
        conv_d  = start ? slot_q : conv_q;
        state_d = state_q;
        acc_d   = acc_q;
        step_d  = step_q;
        bin_d   = bin_q;
        if (cap) begin
            slot_d[idx] = dec_bcd;
            bad_d[idx]  = dec_bad;
            mask_d[idx] = 1'b1;
        end
        case (state_q)
            SCAN: if (start) begin
                state_d = CONV;
                acc_d   = '0;
                step_d  = '0;
            end
            CONV: begin
                acc_d  = acc_mul + {10'd0, conv_q[step_q]};
                step_d = step_q + 1'b1;
                if (step_q == 2'd3) begin
                    state_d = DONE;
                    bin_d   = {2'b00, acc_d};
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            word_q  <= '0;
            stab_q  <= '0;
            slot_q  <= '0;
            bad_q   <= '0;
            mask_q  <= '0;
            to_q    <= '0;
            conv_q  <= '0;
            state_q <= SCAN;
            acc_q   <= '0;
            step_q  <= '0;
            bin_q   <= '0;
        end else begin
            meta_q  <= {en3, en2, en1, en0, abcdefg};
            sync_q  <= meta_q;
            word_q  <= {en_n, seg_n};
            stab_q  <= stab_d;
            slot_q  <= slot_d;
            bad_q   <= bad_d;
            mask_q  <= mask_d;
            to_q    <= to_d;
            conv_q  <= conv_d;
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            bin_q   <= bin_d;
        end
    end

    assign bin       = bin_q;
    assign bin_valid = state_q == DONE;
    assign busy      = state_q != SCAN;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: drives a behavioural 4-digit scan onto the reader and
// scores converted values against a queue of expected frames.
module tb_seg7_scan_reader;
    localparam int D  = 14;
    localparam int TO = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [7:0] abcdefg = 8'hFF;
    logic en0 = 1'b0, en1 = 1'b0, en2 = 1'b0, en3 = 1'b0;
    logic [15:0] bin;
    logic bin_valid, seg_err, busy;

    int checks = 0, passed = 0, valid_cnt = 0, err_cnt = 0, e;
    int exp_q[$];

    seg7_scan_reader #(.SEG_ACT_LOW(1'b1), .EN_ACT_LOW(1'b0), .SETTLE_CYC(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .abcdefg(abcdefg),
        .en0(en0), .en1(en1), .en2(en2), .en3(en3),
        .bin(bin), .bin_valid(bin_valid), .seg_err(seg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst === 1'b1) begin
        if (bin_valid) begin
            valid_cnt++;
            checks++;
            if (exp_q.size() == 0)
                $display("FAIL unexpected_bin_valid: bin=%0d, none expected", bin);
            else begin
                e = exp_q.pop_front();
                if (bin !== 16'(e)) $display("FAIL scoreboard_bin: got %0d expected %0d", bin, e);
                else passed++;
            end
        end
        if (seg_err) err_cnt++;
    end

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
            4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
            8: return 7'h7F;  default: return 7'h7B;
        endcase
    endfunction

    task automatic show(input logic [3:0] en, input logic [6:0] g, input int cyc);
        abcdefg = {1'b1, ~g};
        {en3, en2, en1, en0} = en;
        repeat (cyc) @(posedge clk);
    endtask

    task automatic idle(input int cyc);
        show(4'b0000, 7'h00, cyc);
    endtask

    task automatic scan_g(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2, input logic [6:0] g3);
        show(4'b0001, g0, D);
        show(4'b0010, g1, D);
        show(4'b0100, g2, D);
        show(4'b1000, g3, D);
    endtask

    task automatic scan(input int v);
        scan_g(glyph(v / 1000), glyph(v / 100 % 10), glyph(v / 10 % 10), glyph(v % 10));
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (bin !== 16'd0) $display("FAIL reset_bin: got %0d expected 0", bin); else passed++;
        if (bin_valid !== 1'b0) $display("FAIL reset_bin_valid: got %b expected 0", bin_valid); else passed++;
        if (seg_err !== 1'b0) $display("FAIL reset_seg_err: got %b expected 0", seg_err); else passed++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        rst = 1'b1;
        idle(10);
    endtask

    task automatic test_loopback();
        int v0 = valid_cnt, e0 = err_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(1234);
            scan(1234);
        end
        idle(20);
        drain();
        checks += 3;
        if (exp_q.size() != 0) $display("FAIL loopback_drain: %0d pending, expected 0", exp_q.size()); else passed++;
        if (valid_cnt - v0 != 3) $display("FAIL loopback_pulses: got %0d expected 3", valid_cnt - v0); else passed++;
        if (err_cnt != e0) $display("FAIL loopback_seg_err: got %0d expected 0", err_cnt - e0); else passed++;
    endtask

    task automatic test_values();
        int vals[4] = '{0, 9, 10, 9999};
        int e0 = err_cnt;
        foreach (vals[i]) begin
            exp_q.push_back(vals[i]);
            scan(vals[i]);
            idle(10);
        end
        drain();
        checks += 2;
        if (exp_q.size() != 0) $display("FAIL values_drain: %0d pending, expected 0", exp_q.size()); else passed++;
        if (err_cnt != e0) $display("FAIL values_seg_err: got %0d expected 0", err_cnt - e0); else passed++;
    endtask

    task automatic test_alt_glyphs();
        exp_q.push_back(7979);
        scan_g(7'h72, 7'h73, 7'h70, 7'h7B);
        idle(20);
        drain();
        checks++;
        if (exp_q.size() != 0) $display("FAIL alt_glyph_drain: %0d pending, expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_bad_glyph();
        int v0 = valid_cnt, e0 = err_cnt;
        scan_g(glyph(1), glyph(2), 7'b0000001, glyph(4));
        idle(20);
        checks += 2;
        if (err_cnt - e0 != 1) $display("FAIL bad_glyph_err: got %0d pulses expected 1", err_cnt - e0); else passed++;
        if (valid_cnt != v0) $display("FAIL bad_glyph_valid: got %0d pulses expected 0", valid_cnt - v0); else passed++;
        exp_q.push_back(4321);
        scan(4321);
        idle(20);
        drain();
        checks++;
        if (exp_q.size() != 0) $display("FAIL bad_glyph_recover: %0d pending, expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_glitch();
        exp_q.push_back(5301);
        show(4'b0001, glyph(5), D);
        show(4'b0010, glyph(3), D);
        show(4'b0100, glyph(0), D);
        show(4'b1000, glyph(9), 3);
        show(4'b1000, glyph(1), D);
        idle(20);
        drain();
        checks++;
        if (exp_q.size() != 0) $display("FAIL glitch_drain: %0d pending, expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_overlap();
        int v0 = valid_cnt, e0 = err_cnt;
        show(4'b0011, glyph(8), 2 * D);
        show(4'b0100, glyph(1), D);
        show(4'b1000, glyph(2), D);
        idle(TO + 20);
        checks += 2;
        if (valid_cnt != v0) $display("FAIL overlap_valid: got %0d pulses expected 0", valid_cnt - v0); else passed++;
        if (err_cnt != e0) $display("FAIL overlap_err: got %0d pulses expected 0", err_cnt - e0); else passed++;
        exp_q.push_back(5678);
        scan(5678);
        idle(20);
        drain();
        checks++;
        if (exp_q.size() != 0) $display("FAIL overlap_recover: %0d pending, expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_timeout();
        int v0 = valid_cnt, e0 = err_cnt;
        show(4'b0001, glyph(1), D);
        show(4'b0010, glyph(2), D);
        idle(TO + 20);
        show(4'b0100, glyph(3), D);
        show(4'b1000, glyph(4), D);
        idle(30);
        checks += 2;
        if (valid_cnt != v0) $display("FAIL timeout_valid: got %0d pulses expected 0", valid_cnt - v0); else passed++;
        if (err_cnt != e0) $display("FAIL timeout_err: got %0d pulses expected 0", err_cnt - e0); else passed++;
        idle(TO + 20);
        exp_q.push_back(8765);
        scan(8765);
        idle(20);
        drain();
        checks++;
        if (exp_q.size() != 0) $display("FAIL timeout_recover: %0d pending, expected 0", exp_q.size()); else passed++;
    endtask

    task automatic test_reset_conv();
        bit seen = 0;
        show(4'b0001, glyph(8), D);
        show(4'b0010, glyph(8), D);
        show(4'b0100, glyph(8), D);
        show(4'b1000, glyph(8), 0);
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            seen = busy;
        end
        checks++;
        if (!seen) $display("FAIL reset_conv_busy_wait: busy never rose within 60 cycles");
        else passed++;
        rst = 1'b0;
        #1;
        checks += 3;
        if (busy !== 1'b0) $display("FAIL reset_conv_busy: got %b expected 0", busy); else passed++;
        if (bin !== 16'd0) $display("FAIL reset_conv_bin: got %0d expected 0", bin); else passed++;
        if (bin_valid !== 1'b0) $display("FAIL reset_conv_valid: got %b expected 0", bin_valid); else passed++;
        idle(3);
        rst = 1'b1;
        idle(10);
        exp_q.push_back(2468);
        scan(2468);
        idle(20);
        drain();
        checks++;
        if (exp_q.size() != 0) $display("FAIL reset_conv_recover: %0d pending, expected 0", exp_q.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_values();
        test_alt_glyphs();
        test_bad_glyph();
        test_glitch();
        test_overlap();
        test_timeout();
        test_reset_conv();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
